serial_add_arbiter: RTL and testbench

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 132 +++++++++++++
 tb/tb_serial_add_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end feeding a single bit-serial adder.
// One operand pair is accepted in IDLE, added LSB first over W cycles, then held in DONE.
module serial_add_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         busy
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          id_q, id_d;
    logic          last_q, last_d;

    logic          gnt0, gnt1;
    logic          fa_s, fa_c;

    // Grant only in IDLE and never during reset; on a tie the requester
    // not granted last wins (last_q == 1 favours requester 0).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state_q == ST_IDLE) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        fa_s = a_q[0] ^ b_q[0] ^ carry_q;
        fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? req1_a : req0_a;
                    b_d     = gnt1 ? req1_b : req0_b;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d     = {1'b0, a_q[W-1:1]};
                b_d     = {1'b0, b_q[W-1:1]};
                sum_d   = {fa_s, sum_q[W-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_id     = id_q;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = carry_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter at W=8: vector table plus hand-written
// sequences for arbitration, response hold and mid-operation reset.
module tb_serial_add_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    int pass_cnt = 0;
    int total_cnt = 0;

    serial_add_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE; returns in IDLE after the response is taken.
    task automatic do_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] s, input logic c, input string tag);
        if (sel) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        check({tag, " ready_sel"}, sel ? req1_ready : req0_ready, 1);
        check({tag, " ready_other"}, sel ? req0_ready : req1_ready, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        check({tag, " busy_shift"}, busy, 1);
        check({tag, " ready_shift"}, {req0_ready, req1_ready}, 0);
        repeat (W - 1) step();
        check({tag, " valid_early"}, rsp_valid, 0);
        step();
        check({tag, " valid"}, rsp_valid, 1);
        check({tag, " sum"}, rsp_sum, s);
        check({tag, " cout"}, rsp_cout, c);
        check({tag, " id"}, rsp_id, sel);
        step();
        rsp_ready = 1'b0;
        check({tag, " idle_after"}, {busy, rsp_valid}, 0);
    endtask

    int           g_cyc[$];
    logic         g_id[$];
    int           r_cyc[$];
    logic         r_id[$];
    logic [W-1:0] r_sum[$];
    logic [W-1:0] hold_sum;
    logic         hold_id;
    int           seen_valid;

    initial begin
        vecs[0] = '{sel: 1'b0, a: 8'h01, b: 8'h02, sum: 8'h03, cout: 1'b0};
        vecs[1] = '{sel: 1'b1, a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{sel: 1'b1, a: 8'hAA, b: 8'h55, sum: 8'hFF, cout: 1'b0};
        vecs[3] = '{sel: 1'b0, a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1};
        vecs[4] = '{sel: 1'b0, a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0};
        vecs[5] = '{sel: 1'b1, a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};

        // Reset with both requesters already valid
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h05;
        step();
        step();
        check("rst ready", {req0_ready, req1_ready}, 0);
        check("rst busy", busy, 0);
        check("rst valid", rsp_valid, 0);
        check("rst sum", rsp_sum, 0);
        check("rst cout", rsp_cout, 0);
        check("rst id", rsp_id, 0);

        // Both valid continuously: grants alternate starting with requester 0
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            check("one_hot ready", req0_ready & req1_ready, 0);
            if (req0_ready) begin g_cyc.push_back(c); g_id.push_back(1'b0); end
            if (req1_ready) begin g_cyc.push_back(c); g_id.push_back(1'b1); end
            if (rsp_valid) begin
                r_cyc.push_back(c); r_id.push_back(rsp_id); r_sum.push_back(rsp_sum);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        check("alt grant count", g_cyc.size(), 4);
        check("alt rsp count", r_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("alt grant id", (k < g_id.size()) ? 32'(g_id[k]) : 32'hDEAD, 32'(k % 2));
            check("alt grant cyc", (k < g_cyc.size()) ? g_cyc[k] : -1, 10 * k);
            check("alt rsp id", (k < r_id.size()) ? 32'(r_id[k]) : 32'hDEAD, 32'(k % 2));
            check("alt rsp cyc", (k < r_cyc.size()) ? r_cyc[k] : -1, 10 * k + 9);
            check("alt rsp sum", (k < r_sum.size()) ? 32'(r_sum[k]) : 32'hDEAD,
                  (k % 2 == 0) ? 32'h03 : 32'h15);
        end

        // Vector table, one requester at a time
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout,
                  $sformatf("vec%0d", i));
        end

        // Response held in DONE while rsp_ready is low; competing request waits
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06;
        #1;
        check("hold accept", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
        repeat (W) step();
        check("hold valid0", rsp_valid, 1);
        hold_sum = rsp_sum;
        hold_id  = rsp_id;
        check("hold sum0", hold_sum, 8'h0B);
        check("hold id0", hold_id, 0);
        for (int h = 0; h < 5; h++) begin
            step();
            check("hold valid", rsp_valid, 1);
            check("hold sum", rsp_sum, hold_sum);
            check("hold id", rsp_id, hold_id);
            check("hold ready", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("leave done ready", req1_ready, 0);
        step();
        rsp_ready = 1'b0;
        check("idle req1 ready", req1_ready, 1);
        req1_valid = 1'b0;
        #1;
        check("idle no ready", req1_ready, 0);

        // Reset at the 4th SHIFT edge discards the operation
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20;
        #1;
        check("mid accept", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid busy", busy, 0);
        check("mid valid", rsp_valid, 0);
        check("mid sum", rsp_sum, 0);
        check("mid cout", rsp_cout, 0);
        check("mid id", rsp_id, 0);
        seen_valid = 0;
        repeat (12) begin
            if (rsp_valid) seen_valid++;
            step();
        end
        check("mid no rsp", seen_valid, 0);
        rsp_ready = 1'b0;
        do_op(1'b1, 8'h10, 8'h20, 8'h30, 1'b0, "reissue");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
